// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter over four valid/ready channels feeding a 4:1 mux,
// with a single-entry registered output stage carrying data and source index.
module rr_arb_mux_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic [1:0]   sel,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src,
    input  logic         out_ready
);

    logic [3:0][W-1:0] data;
    logic [1:0]        last;
    logic [1:0]        g;
    logic              found;
    logic              any;
    logic              load_en;
    logic              xfer;

    assign data    = {in_data3, in_data2, in_data1, in_data0};
    assign any     = |in_valid;
    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && any;

    // Scan last+1 .. last+4 (mod 4); offset 4 wraps back onto last itself.
    always_comb begin
        g     = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && in_valid[last + 2'(k)]) begin
                g     = last + 2'(k);
                found = 1'b1;
            end
        end
    end

    assign sel = any ? g : last;

    // Accept strobes are held low while reset is asserted so no upstream
    // channel believes a word was taken that the reset is about to discard.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign in_ready[i] = rst_n && xfer && (g == 2'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last      <= 2'd3;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (xfer) begin
            last      <= g;
            out_valid <= 1'b1;
            out_data  <= data[g];
            out_src   <= g;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Scoreboard bench: driver predicts grants from a rotating-priority model and
// queues expected words; a negedge monitor checks the output register against it.
module tb_rr_arb_mux_4_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_ready;
    logic [1:0] sel;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_ready;

    rr_arb_mux_4_1 #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(in_data0), .in_data1(in_data1),
        .in_data2(in_data2), .in_data3(in_data3),
        .in_ready(in_ready), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] s;
    } item_t;

    item_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    m_last;
    bit    mon_en = 1'b0;

    // Highest-priority requester starting just after the previous grant.
    function automatic int pick(input int lst, input logic [3:0] v);
        for (int k = 1; k <= 4; k++)
            if (v[(lst + k) % 4]) return (lst + k) % 4;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive, check combinational outputs, advance model at edge.
    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] d0,
                        input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                        input logic ordy);
        int    gi;
        bit    occ, xfer;
        item_t it;
        logic [3:0] dsel;
        rst_n = r; in_valid = v; out_ready = ordy;
        in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
        #1;
        gi   = pick(m_last, v);
        occ  = (q.size() != 0);
        xfer = r && (!occ || ordy) && (gi >= 0);
        chk("sel", int'(sel), (gi >= 0) ? gi : m_last);
        chk("in_ready", int'(in_ready), xfer ? (1 << gi) : 0);
        case (gi)
            0: dsel = d0;
            1: dsel = d1;
            2: dsel = d2;
            default: dsel = d3;
        endcase
        it.d = dsel;
        it.s = 2'(gi);
        @(posedge clk);
        if (!r) begin
            q.delete();
            m_last = 3;
        end else if (xfer) begin
            q.push_back(it);
            m_last = gi;
        end
        #1;
        if (!r) begin
            chk("rst_out_data", int'(out_data), 0);
            chk("rst_out_src", int'(out_src), 0);
        end
    endtask

    // Monitor: the queue models the output register contents.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
                if (q.size() != 0) begin
                    chk("out_data", int'(out_data), int'(q[0].d));
                    chk("out_src", int'(out_src), int'(q[0].s));
                    if (out_valid && out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
        @(posedge clk); #1;
        m_last = 3;
        mon_en = 1'b1;

        // Reset held with all channels requesting, then full rotation.
        repeat (2) step(1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
        repeat (9) step(1'b1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);

        // Sparse requests 1010.
        step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        repeat (6) step(1'b1, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);

        // Backpressure after first word from channel 0.
        step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        step(1'b1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
        repeat (3) step(1'b1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0);
        repeat (2) step(1'b1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);

        // Single requester then idle; sel must hold at 2.
        step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        repeat (3) step(1'b1, 4'h4, 4'h0, 4'h0, 4'h5, 4'h0, 1'b1);
        repeat (3) step(1'b1, 4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 1'b1);

        // Mid-operation reset while a word from channel 2 is held.
        step(1'b1, 4'h2, 4'h0, 4'h7, 4'h0, 4'h0, 1'b1);
        step(1'b1, 4'h4, 4'h0, 4'h0, 4'h9, 4'h0, 1'b0);
        step(1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        repeat (2) step(1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);

        // Randomized traffic with occasional backpressure and reset.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7));
        end
        step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
